// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite renderer.
package sprite_pkg;

    localparam int unsigned SPRITE_W_DEF = 128;
    localparam int unsigned SPRITE_H_DEF = 128;
    localparam int unsigned ROM_AW       = 14;
    localparam int unsigned RGB_W        = 12;
    localparam int unsigned COORD_W      = 10;
    localparam logic [RGB_W-1:0] TRANSPARENT_DEF = 12'hF0F;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_e;

endpackage

// File: rtl/sprite_addr_calc.sv
// Combinational box test and sprite ROM address generation.
// Horizontal mirroring exists only when P1_SPRITE_FLIP_EN is defined.
module sprite_addr_calc
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = SPRITE_W_DEF,
    parameter int unsigned SPRITE_H = SPRITE_H_DEF
) (
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic               video_on,
    input  logic               flip,
    output logic               in_box_c,
    output logic [ROM_AW-1:0]  addr_c
);

    localparam int unsigned SUM_W = COORD_W + 1;

    logic [SUM_W-1:0] h_ext;
    logic [SUM_W-1:0] v_ext;
    logic [SUM_W-1:0] x_lo;
    logic [SUM_W-1:0] x_hi;
    logic [SUM_W-1:0] y_lo;
    logic [SUM_W-1:0] y_hi;
    logic [SUM_W-1:0] col_off;
    logic [SUM_W-1:0] row_off;
    logic [SUM_W-1:0] col;

`ifndef P1_SPRITE_FLIP_EN
    logic unused_flip;
    assign unused_flip = flip;
`endif

    // One extra bit keeps the far edge from wrapping past 1023.
    always_comb begin
        h_ext    = SUM_W'(hcount);
        v_ext    = SUM_W'(vcount);
        x_lo     = SUM_W'(px);
        y_lo     = SUM_W'(py);
        x_hi     = x_lo + SUM_W'(SPRITE_W - 1);
        y_hi     = y_lo + SUM_W'(SPRITE_H - 1);
        in_box_c = video_on && (h_ext >= x_lo) && (h_ext <= x_hi)
                            && (v_ext >= y_lo) && (v_ext <= y_hi);
        col_off  = h_ext - x_lo;
        row_off  = v_ext - y_lo;
`ifdef P1_SPRITE_FLIP_EN
        col      = flip ? (SUM_W'(SPRITE_W - 1) - col_off) : col_off;
`else
        col      = col_off;
`endif
        addr_c   = ROM_AW'(row_off) * ROM_AW'(SPRITE_W) + ROM_AW'(col);
    end

endmodule

// File: rtl/p1_sprite_renderer.sv
// Three-stage sprite pipeline: box/address, ROM align, colour-key output.
// Optional horizontal mirror enabled by defining P1_SPRITE_FLIP_EN.
module p1_sprite_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned       SPRITE_W    = SPRITE_W_DEF,
    parameter int unsigned       SPRITE_H    = SPRITE_H_DEF,
    parameter logic [RGB_W-1:0]  TRANSPARENT = TRANSPARENT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               video_on,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               facing_left,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [RGB_W-1:0]   rom_data,
    output logic [RGB_W-1:0]   pixel_out,
    output logic               pixel_valid
);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;
    logic               in_box_q, in_box_d;
    logic               in_box_dly_q, in_box_dly_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic [RGB_W-1:0]   pixel_out_q, pixel_out_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic               flip_c;
    logic               calc_in_box_c;
    logic [ROM_AW-1:0]  calc_addr_c;
    logic               hit_c;

`ifdef P1_SPRITE_FLIP_EN
    logic flip_q, flip_d;
    assign flip_c = flip_q;
`else
    logic unused_facing_left;
    assign unused_facing_left = facing_left;
    assign flip_c             = 1'b0;
`endif

    sprite_addr_calc #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_addr_calc (
        .hcount   (hcount),
        .vcount   (vcount),
        .px       (px_q),
        .py       (py_q),
        .video_on (video_on),
        .flip     (flip_c),
        .in_box_c (calc_in_box_c),
        .addr_c   (calc_addr_c)
    );

    // Next state, position latch and pipeline stages.
    always_comb begin
        state_d       = state_q;
        px_d          = px_q;
        py_d          = py_q;
`ifdef P1_SPRITE_FLIP_EN
        flip_d        = flip_q;
`endif
        hit_c         = (state_q == RUN) && calc_in_box_c;
        in_box_d      = hit_c;
        rom_addr_d    = hit_c ? calc_addr_c : rom_addr_q;
        in_box_dly_d  = in_box_q;
        pixel_valid_d = in_box_dly_q && (rom_data != TRANSPARENT);
        pixel_out_d   = pixel_valid_d ? rom_data : RGB_W'(0);

        if (frame_start) begin
            state_d = RUN;
            px_d    = pos_x;
            py_d    = pos_y;
`ifdef P1_SPRITE_FLIP_EN
            flip_d  = facing_left;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_FRAME;
            px_q          <= '0;
            py_q          <= '0;
`ifdef P1_SPRITE_FLIP_EN
            flip_q        <= 1'b0;
`endif
            in_box_q      <= 1'b0;
            in_box_dly_q  <= 1'b0;
            rom_addr_q    <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            px_q          <= px_d;
            py_q          <= py_d;
`ifdef P1_SPRITE_FLIP_EN
            flip_q        <= flip_d;
`endif
            in_box_q      <= in_box_d;
            in_box_dly_q  <= in_box_dly_d;
            rom_addr_q    <= rom_addr_d;
            pixel_out_q   <= pixel_out_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_p1_sprite_renderer.sv
// Directed testbench for p1_sprite_renderer with a synchronous ROM model.
module tb_p1_sprite_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        video_on;
    logic        frame_start;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        facing_left;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] pixel_out;
    logic        pixel_valid;

    logic        force_en;
    logic [11:0] force_val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    p1_sprite_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .video_on    (video_on),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .facing_left (facing_left),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid)
    );

    // ROM contents: address + 1 (low 12 bits), or a forced constant.
    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        if (force_en) return force_val;
        return 12'(a) + 12'd1;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    // Present one scan position for one cycle; returns 1 time unit after the edge.
    task automatic drive(input logic [9:0] h, input logic [9:0] v,
                         input logic von, input logic fs);
        hcount      = h;
        vcount      = v;
        video_on    = von;
        frame_start = fs;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic idle();
        drive(10'd0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic new_frame(input logic [9:0] x, input logic [9:0] y, input logic fl);
        pos_x       = x;
        pos_y       = y;
        facing_left = fl;
        drive(10'd0, 10'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) idle();
        reset = 1'b0;
        total++; if (rom_addr !== 14'd0) begin bad++; $display("FAIL reset_rom_addr got=%0d want=0", rom_addr); end
        total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL reset_pixel_out got=%h want=000", pixel_out); end
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_pixel_valid got=%b want=0", pixel_valid); end
    endtask

    task automatic test_wait_frame();
        drive(10'd5, 10'd5, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd0) begin bad++; $display("FAIL wait_rom_addr got=%0d want=0", rom_addr); end
        idle(); idle();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL wait_valid got=%b want=0", pixel_valid); end
    endtask

    task automatic test_basic();
        new_frame(10'd100, 10'd50, 1'b0);
        drive(10'd100, 10'd50, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd0) begin bad++; $display("FAIL basic_addr got=%0d want=0", rom_addr); end
        drive(10'd101, 10'd50, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd1) begin bad++; $display("FAIL basic_addr1 got=%0d want=1", rom_addr); end
        idle();
        total++; if (pixel_out !== 12'h001 || pixel_valid !== 1'b1) begin bad++; $display("FAIL basic_pixel got=%h/%b want=001/1", pixel_out, pixel_valid); end
        idle();
        total++; if (pixel_out !== 12'h002 || pixel_valid !== 1'b1) begin bad++; $display("FAIL basic_pixel1 got=%h/%b want=002/1", pixel_out, pixel_valid); end
        drive(10'd100, 10'd50, 1'b0, 1'b0);
        idle(); idle();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL basic_video_off got=%b want=0", pixel_valid); end
    endtask

    task automatic test_flip();
        logic [13:0] exp_addr;
        logic [11:0] exp_pix;
`ifdef P1_SPRITE_FLIP_EN
        exp_addr = 14'd255;
        exp_pix  = 12'h100;
`else
        exp_addr = 14'd128;
        exp_pix  = 12'h081;
`endif
        new_frame(10'd100, 10'd50, 1'b1);
        drive(10'd100, 10'd51, 1'b1, 1'b0);
        total++; if (rom_addr !== exp_addr) begin bad++; $display("FAIL flip_addr got=%0d want=%0d", rom_addr, exp_addr); end
        idle(); idle();
        total++; if (pixel_out !== exp_pix) begin bad++; $display("FAIL flip_pixel got=%h want=%h", pixel_out, exp_pix); end
        new_frame(10'd100, 10'd50, 1'b0);
    endtask

    task automatic test_transparency();
        force_en  = 1'b1;
        force_val = 12'hF0F;
        drive(10'd110, 10'd60, 1'b1, 1'b0);
        idle(); idle();
        total++; if (pixel_valid !== 1'b0 || pixel_out !== 12'h000) begin bad++; $display("FAIL transp_key got=%h/%b want=000/0", pixel_out, pixel_valid); end
        force_val = 12'h0A3;
        drive(10'd110, 10'd60, 1'b1, 1'b0);
        idle(); idle();
        total++; if (pixel_valid !== 1'b1 || pixel_out !== 12'h0A3) begin bad++; $display("FAIL transp_opaque got=%h/%b want=0a3/1", pixel_out, pixel_valid); end
        force_en = 1'b0;
    endtask

    task automatic test_edges();
        drive(10'd227, 10'd177, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd16383) begin bad++; $display("FAIL edge_last_addr got=%0d want=16383", rom_addr); end
        idle(); idle();
        total++; if (pixel_valid !== 1'b1 || pixel_out !== 12'h000) begin bad++; $display("FAIL edge_last_pixel got=%h/%b want=000/1", pixel_out, pixel_valid); end
        drive(10'd228, 10'd177, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd16383) begin bad++; $display("FAIL edge_hold_addr got=%0d want=16383", rom_addr); end
        idle(); idle();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL edge_right got=%b want=0", pixel_valid); end
        drive(10'd99, 10'd50, 1'b1, 1'b0);
        idle(); idle();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL edge_left got=%b want=0", pixel_valid); end
        drive(10'd100, 10'd178, 1'b1, 1'b0);
        idle(); idle();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL edge_bottom got=%b want=0", pixel_valid); end
    endtask

    task automatic test_position_change();
        pos_x = 10'd300;
        drive(10'd100, 10'd50, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd0) begin bad++; $display("FAIL pos_nolatch_addr got=%0d want=0", rom_addr); end
        idle(); idle();
        total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL pos_nolatch_valid got=%b want=1", pixel_valid); end
        new_frame(10'd300, 10'd50, 1'b0);
        drive(10'd302, 10'd50, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd2) begin bad++; $display("FAIL pos_new_addr got=%0d want=2", rom_addr); end
        drive(10'd100, 10'd50, 1'b1, 1'b0);
        idle();
        total++; if (pixel_valid !== 1'b1 || pixel_out !== 12'h003) begin bad++; $display("FAIL pos_new_pixel got=%h/%b want=003/1", pixel_out, pixel_valid); end
        idle();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL pos_old_gone got=%b want=0", pixel_valid); end
        new_frame(10'd600, 10'd50, 1'b0);
        drive(10'd10, 10'd50, 1'b1, 1'b0);
        idle(); idle();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL pos_nowrap got=%b want=0", pixel_valid); end
        drive(10'd727, 10'd50, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd127) begin bad++; $display("FAIL pos_clip_addr got=%0d want=127", rom_addr); end
        idle(); idle();
        total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL pos_clip_valid got=%b want=1", pixel_valid); end
    endtask

    task automatic test_coincident();
        new_frame(10'd100, 10'd50, 1'b0);
        pos_x = 10'd200;
        drive(10'd100, 10'd50, 1'b1, 1'b1);
        total++; if (rom_addr !== 14'd0) begin bad++; $display("FAIL coin_addr got=%0d want=0", rom_addr); end
        drive(10'd100, 10'd50, 1'b1, 1'b0);
        idle();
        total++; if (pixel_valid !== 1'b1 || pixel_out !== 12'h001) begin bad++; $display("FAIL coin_old got=%h/%b want=001/1", pixel_out, pixel_valid); end
        idle();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL coin_new got=%b want=0", pixel_valid); end
    endtask

    task automatic test_corner();
        new_frame(10'd0, 10'd0, 1'b0);
        drive(10'd0, 10'd0, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd0) begin bad++; $display("FAIL corner_addr0 got=%0d want=0", rom_addr); end
        drive(10'd127, 10'd127, 1'b1, 1'b0);
        total++; if (rom_addr !== 14'd16383) begin bad++; $display("FAIL corner_addr_last got=%0d want=16383", rom_addr); end
        idle();
        total++; if (pixel_valid !== 1'b1 || pixel_out !== 12'h001) begin bad++; $display("FAIL corner_pixel0 got=%h/%b want=001/1", pixel_out, pixel_valid); end
        idle();
        total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL corner_pixel_last got=%b want=1", pixel_valid); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        new_frame(10'd100, 10'd50, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(10'(100 + i), 10'd50, 1'b1, 1'b0);
            else       idle();
            if (i >= 2) begin
                exp = 12'(i - 2 + 1);
                total++;
                if (pixel_valid !== 1'b1 || pixel_out !== exp) begin
                    bad++;
                    $display("FAIL b2b_%0d got=%h/%b want=%h/1", i - 2, pixel_out, pixel_valid, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(10'd100, 10'd50, 1'b1, 1'b0);
        drive(10'd101, 10'd50, 1'b1, 1'b0);
        reset = 1'b1;
        drive(10'd102, 10'd50, 1'b1, 1'b0);
        reset = 1'b0;
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", pixel_valid); end
        total++; if (rom_addr !== 14'd0) begin bad++; $display("FAIL rst_mid_addr got=%0d want=0", rom_addr); end
        for (int i = 0; i < 5; i++) begin
            drive(10'(100 + i), 10'd50, 1'b1, 1'b0);
            total++;
            if (pixel_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_%0d got=%b want=0", i, pixel_valid); end
        end
        new_frame(10'd100, 10'd50, 1'b0);
        drive(10'd100, 10'd50, 1'b1, 1'b0);
        idle(); idle();
        total++; if (pixel_valid !== 1'b1 || pixel_out !== 12'h001) begin bad++; $display("FAIL rst_resume got=%h/%b want=001/1", pixel_out, pixel_valid); end
    endtask

    initial begin
        reset       = 1'b1;
        hcount      = '0;
        vcount      = '0;
        video_on    = 1'b0;
        frame_start = 1'b0;
        pos_x       = '0;
        pos_y       = '0;
        facing_left = 1'b0;
        force_en    = 1'b0;
        force_val   = '0;
        #1;
        test_reset();
        test_wait_frame();
        test_basic();
        test_flip();
        test_transparency();
        test_edges();
        test_position_change();
        test_coincident();
        test_corner();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/p1_sprite_renderer.md
P1_SPRITE_RENDERER -- requirements
Module: p1_sprite_renderer

Interface
REQ-001 Parameter SPRITE_W, default 128, meaning sprite width in pixels.
REQ-002 Parameter SPRITE_H, default 128, meaning sprite height in pixels.
REQ-003 Parameter TRANSPARENT, default 12'hF0F, meaning RGB 4:4:4 colour key treated as see-through.
REQ-004 clk  input  1  single system/pixel clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 hcount  input  10  current scan column.
REQ-007 vcount  input  10  current scan row.
REQ-008 video_on  input  1  high inside the visible area.
REQ-009 frame_start  input  1  one-cycle pulse at the start of vertical blanking.
REQ-010 pos_x  input  10  requested sprite left edge.
REQ-011 pos_y  input  10  requested sprite top edge.
REQ-012 facing_left  input  1  requested horizontal mirror.
REQ-013 rom_addr  output  14  address to the sprite ROM, registered.
REQ-014 rom_data  input  12  ROM pixel, valid one cycle after rom_addr.
REQ-015 pixel_out  output  12  sprite colour, registered.
REQ-016 pixel_valid  output  1  high when pixel_out is an opaque sprite pixel.

Function
REQ-017 Position latch: pos_x, pos_y and facing_left SHALL be captured into internal registers only on cycles with frame_start=1; there SHALL be no mid-frame change.
REQ-018 Stage 1 (cycle N+1): in_box SHALL register as video_on && hcount in [px, px+SPRITE_W-1] && vcount in [py, py+SPRITE_H-1], using the latched position.
REQ-019 Comparisons SHALL use 11-bit sums so px+SPRITE_W-1 above 1023 does not wrap, with the box clipped at the far edge.
REQ-020 Stage 1 address: col=hcount-px, row=vcount-py, and rom_addr=row*SPRITE_W+col; when facing_left=1 latched, col SHALL be SPRITE_W-1-(hcount-px).
REQ-021 When in_box is 0, rom_addr SHALL hold its previous value so the ROM does not toggle outside the box.
REQ-022 Stage 2 (cycle N+2): in_box SHALL be delayed one cycle to align with rom_data.
REQ-023 Stage 3 (cycle N+3): pixel_valid SHALL register as in_box_d && rom_data != TRANSPARENT.
REQ-024 Stage 3 colour: pixel_out SHALL be rom_data when pixel_valid is 1, else 12'h000.
REQ-025 Total latency from hcount/vcount to pixel_out SHALL be exactly 3 cycles, fixed with no bubbles.
REQ-026 Two-state FSM:
- WAIT_FRAME: after reset, until the first frame_start.
- RUN: entered on that frame_start.
- In WAIT_FRAME, in_box SHALL be forced to 0.
REQ-027 A frame_start asserted coincident with an in-box pixel SHALL update the position for the next cycle; the in-flight pixels SHALL complete with the old values.
REQ-028 pos_x=0, pos_y=0 SHALL be legal; the sprite at the top-left corner SHALL render fully.

Reset
REQ-029 Reset SHALL clear rom_addr, pixel_out, pixel_valid, all pipeline flags and latched position to 0, and enter WAIT_FRAME.
REQ-030 Reset asserted mid-line SHALL discard in-flight pixels; pixel_valid SHALL be 0 on the cycle after reset.

Configuration
REQ-031 Macro P1_SPRITE_FLIP_EN:
- When defined, facing_left SHALL mirror per REQ-020.
- When undefined, facing_left SHALL be ignored and never mirror.
- When undefined, the flip subtractor SHALL be absent.

Structure
REQ-032 A shared package sprite_pkg SHALL hold:
- SPRITE_W_DEF=128, SPRITE_H_DEF=128.
- ROM_AW=14, RGB_W=12.
- TRANSPARENT_DEF=12'hF0F.
- Screen constants H_VISIBLE=640, V_VISIBLE=480.
REQ-033 One sub-module, sprite_addr_calc, SHALL be used: combinational in_box, col/row, flip and address computation.
REQ-034 The ROM SHALL stay external; this block only drives the address and consumes data.

Verification
REQ-035 Basic pixel:
- Stimulus: reset, frame_start with pos=(100,50), facing_left=0, then scan (100,50).
- Response: rom_addr=0 at N+1, pixel_out=rom_data[0] at N+3, pixel_valid=1.
REQ-036 Flip:
- Stimulus: P1_SPRITE_FLIP_EN defined, facing_left=1, scan (100,51).
- Response: rom_addr=128+127=255.
- Stimulus: same scan, macro undefined.
- Response: rom_addr=128.
REQ-037 Transparency:
- Stimulus: ROM returns 12'hF0F inside the box.
- Response: pixel_valid=0, pixel_out=12'h000.
- Stimulus: ROM returns 12'h0A3.
- Response: pixel_valid=1, pixel_out=12'h0A3.
REQ-038 Box edges:
- hcount=227 and vcount=177 (last pixel) -> rom_addr=16383.
- hcount=228 -> pixel_valid=0 at N+3.
- hcount=99 -> pixel_valid=0 at N+3.
REQ-039 Position change:
- Stimulus: pos_x changed mid-frame without frame_start.
- Response: output unchanged.
- Stimulus: frame_start is then pulsed.
- Response: the next frame uses the new position.
- Stimulus: pos_x=600.
- Response: clipped, no wrap hit at hcount=10.
REQ-040 Reset:
- Stimulus: reset during an active sprite row.
- Response: pixel_valid=0 next cycle, then no output until the next frame_start.
